info_bit_packer: RTL and testbench
==================================

# info_bit_packer

Downstream stage of the 2-bit leaf decoder in the SC polar decoder. Each accepted beat carries one decoded bit pair (u(2i-1), u(2i)) and its frozen flags. The block drops frozen positions and packs the information bits LSB-first into a K-bit result word. It then presents the word to the output interface with a valid/ready handshake, one codeword at a time.

## Interface
- OUT_W, 140: width of packed result word (maximum K).
- CNT_W, 9: width of pair counter (N_MAX/2 = 256 pairs needs 9 bits).

- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a codeword; sampled only in IDLE.
- n_pairs  in  CNT_W  number of bit pairs in the codeword (N/2); sampled with start.
- in_valid  in  1  bit pair valid this cycle.
- in_ready  out  1  block accepts a pair this cycle.
- u_hat_1  in  1  estimated u(2i-1).
- u_hat_2  in  1  estimated u(2i).
- frozen_1  in  1  u(2i-1) is frozen.
- frozen_2  in  1  u(2i) is frozen.
- out_valid  out  1  dec_bits/dec_cnt valid.
- out_ready  in  1  consumer takes the result.
- dec_bits  out  OUT_W  packed information bits; bit 0 is the first info bit.
- dec_cnt  out  8  number of info bits packed (K).
- ovf  out  1  more than OUT_W info bits were seen in this codeword.

## Operation
- **States:**
  - IDLE → COLLECT on start when n_pairs != 0. This clears dec_bits, dec_cnt, ovf and the pair counter, and latches n_pairs.
  - IDLE → DONE on start with n_pairs == 0. The result is empty, dec_cnt = 0.
  - COLLECT → DONE in the cycle after the handshake of pair number n_pairs−1 (the last pair).
  - DONE → IDLE on out_valid && out_ready.
- in_ready = (state == COLLECT). A pair is accepted on in_valid && in_ready.
- **Packing per accepted pair.** Let k = dec_cnt before the beat.
  - !frozen_1 only: dec_bits[k] = u_hat_1, k += 1.
  - !frozen_2 only: dec_bits[k] = u_hat_2, k += 1.
  - Both info: dec_bits[k] = u_hat_1, dec_bits[k+1] = u_hat_2, k += 2.
  - Both frozen: no write, k unchanged.
  - u_hat values at frozen positions are ignored, whatever their value.
- **Overflow.** Any write at an index >= OUT_W is dropped and sets ovf, which is sticky until the next start. dec_cnt saturates at OUT_W. Lower bits are preserved.
- Bits of dec_bits above dec_cnt are 0.
- **start outside IDLE** is ignored. There is no abort; rst is the only abort.
- **rst at any time** (mid-COLLECT or during DONE) returns the block to IDLE and clears every output register in the same edge.

## Timing
- **Reset values:** state IDLE, in_ready 0, out_valid 0, dec_bits 0, dec_cnt 0, ovf 0.
- **Throughput:** one pair per cycle while in COLLECT and in_valid is high. in_valid gaps are allowed and do not advance the counter.
- **Latency:** out_valid rises 1 cycle after the clock edge that accepts the last pair. It rises 1 cycle after start when n_pairs == 0.
- dec_bits, dec_cnt and ovf are registered and held stable while out_valid && !out_ready.
- out_valid falls on the edge where out_ready is sampled high. The next start is honoured from the following cycle (IDLE).
- in_ready is 0 in the cycle start is sampled and becomes 1 the next cycle.

## Test plan
- **Basic N=8.**
  - Stimulus: start with n_pairs=4; pairs (u1,u2,f1,f2) = (1,0,1,1), (1,1,1,0), (0,1,0,0), (1,1,0,0), back-to-back.
  - Required: out_valid 1 cycle after the 4th accept; dec_cnt=5; dec_bits[4:0]=5'b11101 (bits in order 1,0,1,1,1); upper bits 0; ovf=0.
- **Frozen masking.**
  - Stimulus: all pairs have f1=f2=1 and u_hat=1, n_pairs=64.
  - Required: dec_cnt=0, dec_bits=0.
- **Gaps and backpressure.**
  - Stimulus: n_pairs=3 with in_valid toggling 1,0,1,0,1; then hold out_ready=0 for 5 cycles.
  - Required: exactly 3 pairs consumed; outputs constant for the 5 stall cycles; IDLE the cycle after out_ready=1.
- **Overflow.**
  - Stimulus: n_pairs=256, all info bits, u_hat_1=1, u_hat_2=0.
  - Required: dec_cnt=140; dec_bits alternating 1,0 from bit 0; ovf=1.
- **Zero length / ignored start.**
  - Stimulus: start with n_pairs=0, then start pulses during the DONE stall.
  - Required: out_valid next cycle with dec_cnt=0; extra starts have no effect.
- **Reset mid-codeword.**
  - Stimulus: rst after 2 of 4 pairs.
  - Required: next cycle IDLE, all outputs 0. A following full codeword decodes correctly with no residue from the aborted one.

Source files
------------

// File: rtl/info_bit_packer.sv
// Packs the information bits of one SC polar codeword, LSB-first, from 2-bit leaf pairs.
// The frozen positions are dropped. The packed word is then handed off with a valid/ready handshake.
module info_bit_packer #(
   parameter int OUT_W = 140,
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] n_pairs,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             u_hat_1,
   input  logic             u_hat_2,
   input  logic             frozen_1,
   input  logic             frozen_2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] dec_bits,
   output logic [7:0]       dec_cnt,
   output logic             ovf
);

   localparam logic [7:0] MAX_K = 8'(OUT_W);

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] pair_cnt;
   logic [CNT_W-1:0] n_lat;
   logic             last_pair;
   logic [OUT_W-1:0] bits_nxt;
   logic [7:0]       cnt_nxt;
   logic             ovf_nxt;

   // Every bit above dec_cnt is zero, so an OR places the new bit without a read-modify mask.
   function automatic logic [OUT_W-1:0] put_bit(input logic [OUT_W-1:0] w,
                                                 input logic [7:0] k,
                                                 input logic b);
      return w | ({{(OUT_W-1){1'b0}}, b} << k);
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] k);
      return (k < MAX_K) ? k + 8'd1 : k;
   endfunction

   assign in_ready  = (state == COLLECT);
   assign last_pair = (pair_cnt == n_lat - {{(CNT_W-1){1'b0}}, 1'b1});

   always_comb begin
      bits_nxt = dec_bits;
      cnt_nxt  = dec_cnt;
      ovf_nxt  = ovf;
      if (!frozen_1) begin
         if (cnt_nxt < MAX_K) bits_nxt = put_bit(bits_nxt, cnt_nxt, u_hat_1);
         else                 ovf_nxt  = 1'b1;
         cnt_nxt = sat_inc(cnt_nxt);
      end
      if (!frozen_2) begin
         if (cnt_nxt < MAX_K) bits_nxt = put_bit(bits_nxt, cnt_nxt, u_hat_2);
         else                 ovf_nxt  = 1'b1;
         cnt_nxt = sat_inc(cnt_nxt);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         dec_bits  <= '0;
         dec_cnt   <= 8'd0;
         ovf       <= 1'b0;
         pair_cnt  <= '0;
         n_lat     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  dec_bits <= '0;
                  dec_cnt  <= 8'd0;
                  ovf      <= 1'b0;
                  pair_cnt <= '0;
                  n_lat    <= n_pairs;
                  if (n_pairs == '0) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                  end else begin
                     state <= COLLECT;
                  end
               end
            end
            COLLECT: begin
               // in_ready is high throughout COLLECT, so in_valid alone marks an accepted pair.
               if (in_valid) begin
                  dec_bits <= bits_nxt;
                  dec_cnt  <= cnt_nxt;
                  ovf      <= ovf_nxt;
                  pair_cnt <= pair_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                  if (last_pair) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_info_bit_packer.sv
// Testbench for info_bit_packer. A reference packer computes the expected word for each codeword.
// A monitor pops those expectations from a queue at each output handshake.
module tb_info_bit_packer;

   localparam int OUT_W = 140;
   localparam int CNT_W = 9;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] n_pairs;
   logic             in_valid;
   logic             in_ready;
   logic             u_hat_1, u_hat_2, frozen_1, frozen_2;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] dec_bits;
   logic [7:0]       dec_cnt;
   logic             ovf;

   typedef struct packed {
      logic [OUT_W-1:0] bits;
      logic [7:0]       cnt;
      logic             ovf;
   } res_t;

   res_t             sbq[$];
   res_t             e;
   logic [3:0]       pq[$];
   logic [OUT_W-1:0] m_bits;
   int               m_k;
   logic             m_ovf;
   int               n_vec = 0;
   int               n_err = 0;
   logic [OUT_W-1:0] snap_bits;
   logic [7:0]       snap_cnt;
   logic [OUT_W-1:0] alt;

   info_bit_packer #(.OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .n_pairs(n_pairs),
      .in_valid(in_valid), .in_ready(in_ready),
      .u_hat_1(u_hat_1), .u_hat_2(u_hat_2), .frozen_1(frozen_1), .frozen_2(frozen_2),
      .out_valid(out_valid), .out_ready(out_ready),
      .dec_bits(dec_bits), .dec_cnt(dec_cnt), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic mdl_put(input logic b);
      if (m_k < OUT_W) begin
         m_bits[m_k] = b;
         m_k++;
      end else begin
         m_ovf = 1'b1;
      end
   endtask

   task automatic push_exp();
      res_t r;
      r.bits = m_bits;
      r.cnt  = 8'(m_k);
      r.ovf  = m_ovf;
      sbq.push_back(r);
   endtask

   // mode 0: random pairs, 1: all frozen with u=1, 2: all info with u1=1 and u2=0.
   task automatic fill(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         case (mode)
            1:       pq.push_back(4'b1111);
            2:       pq.push_back(4'b1000);
            default: pq.push_back(4'($urandom_range(0, 15)));
         endcase
      end
   endtask

   task automatic do_start(input int n);
      start   = 1'b1;
      n_pairs = CNT_W'(n);
      chk("rdy_low_at_start", in_ready, 0);
      m_bits = '0;
      m_k    = 0;
      m_ovf  = 1'b0;
      @(negedge clk);
      start = 1'b0;
      if (n == 0) begin
         push_exp();
         chk("zero_len_ovalid", out_valid, 1);
      end else begin
         chk("rdy_after_start", in_ready, 1);
      end
   endtask

   task automatic send_pair(input logic [3:0] p);
      int t;
      {u_hat_1, u_hat_2, frozen_1, frozen_2} = p;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      if (!p[1]) mdl_put(p[3]);
      if (!p[0]) mdl_put(p[2]);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_cw(input int n, input bit gaps, input bit hold);
      do_start(n);
      for (int i = 0; i < n; i++) begin
         if (hold && i == n - 1) out_ready = 1'b0;
         send_pair(pq.pop_front());
         if (i < n - 1) chk("collecting_ovalid", out_valid, 0);
         if (gaps && i < n - 1) @(negedge clk);
      end
      if (n > 0) begin
         push_exp();
         chk("latency_ovalid", out_valid, 1);
         chk("done_in_ready", in_ready, 0);
      end
   endtask

   task automatic expect_idle();
      @(negedge clk);
      chk("idle_ovalid", out_valid, 0);
      chk("idle_in_ready", in_ready, 0);
   endtask

   always begin
      @(negedge clk);
      #1;
      if (!rst && out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            chk("sb_underflow", 1, 0);
         end else begin
            e = sbq.pop_front();
            chk("sb_bits", dec_bits, e.bits);
            chk("sb_cnt", dec_cnt, e.cnt);
            chk("sb_ovf", ovf, e.ovf);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; n_pairs = '0; in_valid = 1'b0; out_ready = 1'b1;
      u_hat_1 = 1'b0; u_hat_2 = 1'b0; frozen_1 = 1'b1; frozen_2 = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dec_bits", dec_bits, 0);
      chk("rst_dec_cnt", dec_cnt, 0);
      chk("rst_ovf", ovf, 0);

      // Basic N=8
      pq.push_back(4'b1011); pq.push_back(4'b1110);
      pq.push_back(4'b0100); pq.push_back(4'b1100);
      run_cw(4, 1'b0, 1'b0);
      chk("basic_cnt", dec_cnt, 5);
      chk("basic_bits", dec_bits, 160'b11101);
      chk("basic_ovf", ovf, 0);
      expect_idle();

      // Frozen masking
      fill(64, 1);
      run_cw(64, 1'b0, 1'b0);
      chk("frozen_cnt", dec_cnt, 0);
      chk("frozen_bits", dec_bits, 0);
      expect_idle();

      // Gaps and backpressure
      fill(3, 0);
      run_cw(3, 1'b1, 1'b1);
      snap_bits = dec_bits;
      snap_cnt  = dec_cnt;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_ovalid", out_valid, 1);
         chk("stall_bits", dec_bits, snap_bits);
         chk("stall_cnt", dec_cnt, snap_cnt);
         chk("stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      expect_idle();

      // Overflow
      fill(256, 2);
      run_cw(256, 1'b0, 1'b0);
      for (int i = 0; i < OUT_W; i++) alt[i] = (i % 2 == 0);
      chk("ovf_cnt", dec_cnt, 140);
      chk("ovf_bits", dec_bits, alt);
      chk("ovf_flag", ovf, 1);
      expect_idle();

      // Zero length and starts ignored while DONE
      out_ready = 1'b0;
      do_start(0);
      chk("zero_cnt", dec_cnt, 0);
      for (int i = 0; i < 2; i++) begin
         start   = 1'b1;
         n_pairs = CNT_W'(5);
         @(negedge clk);
         start = 1'b0;
         chk("ign_start_ovalid", out_valid, 1);
         chk("ign_start_in_ready", in_ready, 0);
         chk("ign_start_cnt", dec_cnt, 0);
      end
      out_ready = 1'b1;
      expect_idle();
      @(negedge clk);
      chk("after_zero_in_ready", in_ready, 0);

      // Reset mid-codeword
      fill(2, 2);
      do_start(4);
      send_pair(pq.pop_front());
      send_pair(pq.pop_front());
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_bits", dec_bits, 0);
      chk("midrst_cnt", dec_cnt, 0);
      chk("midrst_ovf", ovf, 0);
      fill(4, 0);
      run_cw(4, 1'b0, 1'b0);
      expect_idle();

      // Random codewords
      for (int c = 0; c < 5; c++) begin
         int n;
         n = $urandom_range(1, 40);
         fill(n, 0);
         run_cw(n, c[0], 1'b0);
         expect_idle();
      end

      chk("sb_drained", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
